// File: rtl/fattree_dest_addr_encoder_pkg.sv
// Shared fat-tree width helpers and encoder state type, so router-side logic and
// the destination encoder derive identical digit and endpoint widths.
package fattree_dest_addr_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_DONE
    } enc_state_e;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int v = 1; v < value; v = v * 2) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int ipow(input int base, input int exp);
        int r;
        r = 1;
        for (int i = 0; i < exp; i++) begin
            r = r * base;
        end
        return r;
    endfunction

    function automatic int calc_kw(input int k);
        return log2(k);
    endfunction

    function automatic int calc_ne(input int k, input int l);
        return ipow(k, l);
    endfunction

    function automatic int calc_ew(input int k, input int l);
        return log2(ipow(k, l));
    endfunction

endpackage

// File: rtl/fattree_dest_addr_encoder_if.sv
// Request/response bundle between a destination-id producer and the encoder.
interface fattree_dest_addr_encoder_if
    import fattree_dest_addr_encoder_pkg::*;
#(
    parameter int EW  = calc_ew(4, 3),
    parameter int LKW = 3 * calc_kw(4)
);
    logic           in_valid;
    logic           in_ready;
    logic [EW-1:0]  dest_id;
    logic           out_valid;
    logic           out_ready;
    logic [LKW-1:0] dest_addr_encoded;
    logic           out_err;

    modport master (
        output in_valid, dest_id, out_ready,
        input  in_ready, out_valid, dest_addr_encoded, out_err
    );

    modport slave (
        input  in_valid, dest_id, out_ready,
        output in_ready, out_valid, dest_addr_encoded, out_err
    );
endinterface

// File: rtl/fattree_dest_addr_encoder_div_by_k_step.sv
// One restoring-division step by K: shift in a dividend bit, subtract K,
// keep the difference unless it borrowed.
module fattree_div_by_k_step #(
    parameter int KW = 2
) (
    input  logic [KW:0] rem_in,
    input  logic        din,
    input  logic [KW:0] k_val,
    output logic [KW:0] rem_out,
    output logic        q_bit
);
    logic [KW+1:0] trial;
    logic [KW+1:0] diff;

    // The remainder stays below K, so trial < 2K and the top diff bit is the borrow.
    always_comb begin
        trial   = {rem_in, din};
        diff    = trial - {1'b0, k_val};
        q_bit   = ~diff[KW+1];
        rem_out = q_bit ? diff[KW:0] : trial[KW:0];
    end
endmodule

// File: rtl/fattree_dest_addr_encoder.sv
// Converts a binary endpoint number into per-level base-K down-port digits by
// repeated bit-serial division by K; level L-1 gets the least significant digit.
module fattree_dest_addr_encoder
    import fattree_dest_addr_encoder_pkg::*;
#(
    parameter int K = 4,
    parameter int L = 3
) (
    input logic                        clk,
    input logic                        reset,
    fattree_dest_addr_encoder_if.slave bus
);
    localparam int Kw   = calc_kw(K);
    localparam int LKw  = L * Kw;
    localparam int NE   = calc_ne(K, L);
    localparam int Ew   = calc_ew(K, L);
    localparam int LVLW = log2(L);
    localparam int BITW = log2(Ew);

    localparam logic [Kw:0]      K_VAL   = (Kw + 1)'(K);
    localparam logic [Ew:0]      NE_W    = (Ew + 1)'(NE);
    localparam logic [LVLW-1:0]  LVL_MAX = LVLW'(L - 1);
    localparam logic [BITW-1:0]  BIT_MAX = BITW'(Ew - 1);

    enc_state_e      state_q, state_d;
    logic [Ew-1:0]   dividend_q, dividend_d;
    logic [Kw:0]     rem_q, rem_d;
    logic [LVLW-1:0] lvl_q, lvl_d;
    logic [BITW-1:0] bit_q, bit_d;
    logic [LKw-1:0]  addr_q, addr_d;
    logic            err_q, err_d;

    logic [Kw:0]     step_rem;
    logic            step_q;
    logic [Ew:0]     shifted;

    fattree_div_by_k_step #(.KW(Kw)) u_step (
        .rem_in  (rem_q),
        .din     (dividend_q[Ew-1]),
        .k_val   (K_VAL),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dividend_q <= '0;
            rem_q      <= '0;
            lvl_q      <= '0;
            bit_q      <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            rem_q      <= rem_d;
            lvl_q      <= lvl_d;
            bit_q      <= bit_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
        end
    end

    // Quotient bits shift into the dividend's LSB, so after Ew steps it holds the quotient.
    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        rem_d      = rem_q;
        lvl_d      = lvl_q;
        bit_d      = bit_q;
        addr_d     = addr_q;
        err_d      = err_q;
        shifted    = {dividend_q, step_q};

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    dividend_d = bus.dest_id;
                    addr_d     = '0;
                    rem_d      = '0;
                    lvl_d      = LVL_MAX;
                    bit_d      = BIT_MAX;
                    if ({1'b0, bus.dest_id} >= NE_W) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                rem_d      = step_rem;
                dividend_d = shifted[Ew-1:0];
                bit_d      = bit_q - 1'b1;
                if (bit_q == '0) begin
                    addr_d[int'(lvl_q) * Kw +: Kw] = step_rem[Kw-1:0];
                    rem_d = '0;
                    bit_d = BIT_MAX;
                    lvl_d = lvl_q - 1'b1;
                    if (lvl_q == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready          = (state_q == ST_IDLE);
    assign bus.out_valid         = (state_q == ST_DONE);
    assign bus.dest_addr_encoded = addr_q;
    assign bus.out_err           = err_q;
endmodule

// File: tb/tb_fattree_dest_addr_encoder.sv
// Scoreboard bench for the fat-tree destination encoder, exercising three (K,L)
// configurations through one shared driver selected by 'sel'.
module tb_fattree_dest_addr_encoder;

    typedef struct {
        int         id;
        logic [5:0] addr;
        logic       err;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tb_in_valid;
    logic       tb_out_ready;
    logic [5:0] tb_dest;
    int         sel;

    logic       cur_in_ready;
    logic       cur_out_valid;
    logic       cur_err;
    logic [5:0] cur_addr;

    int   cfg_k[3] = '{4, 3, 5};
    int   cfg_l[3] = '{3, 2, 2};
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fattree_dest_addr_encoder_if #(.EW(6), .LKW(6)) bus0 ();
    fattree_dest_addr_encoder_if #(.EW(4), .LKW(4)) bus1 ();
    fattree_dest_addr_encoder_if #(.EW(5), .LKW(6)) bus2 ();

    assign bus0.in_valid  = tb_in_valid && (sel == 0);
    assign bus1.in_valid  = tb_in_valid && (sel == 1);
    assign bus2.in_valid  = tb_in_valid && (sel == 2);
    assign bus0.out_ready = tb_out_ready && (sel == 0);
    assign bus1.out_ready = tb_out_ready && (sel == 1);
    assign bus2.out_ready = tb_out_ready && (sel == 2);
    assign bus0.dest_id   = tb_dest;
    assign bus1.dest_id   = tb_dest[3:0];
    assign bus2.dest_id   = tb_dest[4:0];

    fattree_dest_addr_encoder #(.K(4), .L(3)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    fattree_dest_addr_encoder #(.K(3), .L(2)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    fattree_dest_addr_encoder #(.K(5), .L(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    always_comb begin
        cur_in_ready  = bus0.in_ready;
        cur_out_valid = bus0.out_valid;
        cur_err       = bus0.out_err;
        cur_addr      = bus0.dest_addr_encoded;
        case (sel)
            1: begin
                cur_in_ready  = bus1.in_ready;
                cur_out_valid = bus1.out_valid;
                cur_err       = bus1.out_err;
                cur_addr      = 6'(bus1.dest_addr_encoded);
            end
            2: begin
                cur_in_ready  = bus2.in_ready;
                cur_out_valid = bus2.out_valid;
                cur_err       = bus2.out_err;
                cur_addr      = bus2.dest_addr_encoded;
            end
            default: ;
        endcase
    end

    // Reference: digit i is (id / K**(L-1-i)) mod K; out-of-range ids flag an error in one edge.
    function automatic exp_t model(input int id, input int k, input int l);
        exp_t e;
        int   kw;
        int   ne;
        int   p;
        kw = $clog2(k);
        ne = 1;
        for (int i = 0; i < l; i++) ne = ne * k;
        e.id   = id;
        e.addr = '0;
        e.err  = 1'b0;
        if (id >= ne) begin
            e.err = 1'b1;
            e.lat = 0;
        end else begin
            for (int i = 0; i < l; i++) begin
                p = 1;
                for (int j = 0; j < l - 1 - i; j++) p = p * k;
                e.addr = e.addr | 6'(((id / p) % k) << (i * kw));
            end
            e.lat = l * $clog2(ne);
        end
        return e;
    endfunction

    function automatic int cfg_ew(input int c);
        int ne;
        ne = 1;
        for (int i = 0; i < cfg_l[c]; i++) ne = ne * cfg_k[c];
        return $clog2(ne);
    endfunction

    // Push the expectation, present the request, and count edges after the accepting edge.
    task automatic drive_request(input int id, output int lat);
        int w;
        sb.push_back(model(id, cfg_k[sel], cfg_l[sel]));
        @(negedge clk);
        tb_dest     = 6'(id);
        tb_in_valid = 1'b1;
        w = 0;
        while (!cur_in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        tb_in_valid = 1'b0;
        lat = 0;
        while (!cur_out_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic complete_handshake();
        tb_out_ready = 1'b1;
        @(negedge clk);
        tb_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if ({cur_in_ready, cur_out_valid, cur_err, cur_addr} !== {3'b100, 6'd0}) begin
                errors++;
                $display("[TB] FAIL reset_state cfg%0d: got rdy=%b vld=%b err=%b addr=%0h expected rdy=1 vld=0 err=0 addr=0",
                         s, cur_in_ready, cur_out_valid, cur_err, cur_addr);
            end
        end
        sel = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cur_in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_reset_ready: got %b expected 1", cur_in_ready);
        end
    endtask

    task automatic test_basic();
        int   lat;
        exp_t e;
        sel = 0;
        drive_request(27, lat);
        e = sb.pop_front();
        checks++;
        if (cur_addr !== 6'b111001 || cur_addr !== e.addr) begin
            errors++;
            $display("[TB] FAIL basic_addr: got %b expected %b", cur_addr, e.addr);
        end
        checks++;
        if (cur_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_err: got %b expected 0", cur_err);
        end
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d expected 18", lat);
        end
        complete_handshake();
        checks++;
        if (cur_in_ready !== 1'b1 || cur_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_release: got rdy=%b vld=%b expected rdy=1 vld=0", cur_in_ready, cur_out_valid);
        end
    endtask

    task automatic test_k3_range();
        int   ids[5] = '{7, 12, 8, 9, 15};
        int   lat;
        exp_t e;
        sel = 1;
        foreach (ids[n]) begin
            drive_request(ids[n], lat);
            e = sb.pop_front();
            checks++;
            if ({cur_err, cur_addr} !== {e.err, e.addr}) begin
                errors++;
                $display("[TB] FAIL k3_result id=%0d: got err=%b addr=%b expected err=%b addr=%b",
                         e.id, cur_err, cur_addr, e.err, e.addr);
            end
            checks++;
            if (lat !== e.lat) begin
                errors++;
                $display("[TB] FAIL k3_latency id=%0d: got %0d expected %0d", e.id, lat, e.lat);
            end
            complete_handshake();
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        int   quiet;
        exp_t e;
        sel = 0;
        drive_request(38, lat);
        e = sb.pop_front();
        checks++;
        if ({cur_err, cur_addr} !== {e.err, e.addr} || lat !== e.lat) begin
            errors++;
            $display("[TB] FAIL hold_first: got err=%b addr=%b lat=%0d expected err=%b addr=%b lat=%0d",
                     cur_err, cur_addr, lat, e.err, e.addr, e.lat);
        end
        tb_in_valid = 1'b1;
        tb_dest     = 6'd5;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if ({cur_out_valid, cur_in_ready, cur_err, cur_addr} !== {2'b10, e.err, e.addr}) begin
                errors++;
                $display("[TB] FAIL hold_stable: got vld=%b rdy=%b err=%b addr=%b expected vld=1 rdy=0 err=%b addr=%b",
                         cur_out_valid, cur_in_ready, cur_err, cur_addr, e.err, e.addr);
            end
        end
        tb_in_valid = 1'b0;
        complete_handshake();
        checks++;
        if (cur_in_ready !== 1'b1 || cur_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_release: got rdy=%b vld=%b expected rdy=1 vld=0", cur_in_ready, cur_out_valid);
        end
        quiet = 0;
        repeat (25) begin
            @(negedge clk);
            if (cur_out_valid !== 1'b0 || cur_in_ready !== 1'b1) quiet++;
        end
        checks++;
        if (quiet !== 0) begin
            errors++;
            $display("[TB] FAIL hold_no_queue: got %0d busy cycles expected 0", quiet);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        exp_t e;
        sel = 2;
        drive_request(17, lat);
        e = sb.pop_front();
        checks++;
        if ({cur_err, cur_addr} !== {e.err, e.addr} || lat !== e.lat) begin
            errors++;
            $display("[TB] FAIL b2b_first: got err=%b addr=%b lat=%0d expected err=%b addr=%b lat=%0d",
                     cur_err, cur_addr, lat, e.err, e.addr, e.lat);
        end
        sb.push_back(model(24, cfg_k[sel], cfg_l[sel]));
        tb_out_ready = 1'b1;
        tb_in_valid  = 1'b1;
        tb_dest      = 6'd24;
        @(negedge clk);
        tb_out_ready = 1'b0;
        checks++;
        if (cur_in_ready !== 1'b1 || cur_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_no_bypass: got rdy=%b vld=%b expected rdy=1 vld=0", cur_in_ready, cur_out_valid);
        end
        @(negedge clk);
        tb_in_valid = 1'b0;
        checks++;
        if (cur_in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_accept: got rdy=%b expected 0", cur_in_ready);
        end
        lat = 0;
        while (!cur_out_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if ({cur_err, cur_addr} !== {e.err, e.addr} || lat !== e.lat) begin
            errors++;
            $display("[TB] FAIL b2b_second: got err=%b addr=%b lat=%0d expected err=%b addr=%b lat=%0d",
                     cur_err, cur_addr, lat, e.err, e.addr, e.lat);
        end
        complete_handshake();
    endtask

    task automatic test_reset_mid_div();
        int   lat;
        int   pulses;
        exp_t e;
        sel = 0;
        @(negedge clk);
        tb_dest     = 6'd45;
        tb_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({cur_in_ready, cur_out_valid, cur_err, cur_addr} !== {3'b100, 6'd0}) begin
            errors++;
            $display("[TB] FAIL abort_reset: got rdy=%b vld=%b err=%b addr=%b expected rdy=1 vld=0 err=0 addr=0",
                     cur_in_ready, cur_out_valid, cur_err, cur_addr);
        end
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (cur_out_valid !== 1'b0) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("[TB] FAIL abort_silent: got %0d valid cycles expected 0", pulses);
        end
        drive_request(63, lat);
        e = sb.pop_front();
        checks++;
        if (cur_addr !== 6'b111111 || cur_err !== e.err || lat !== e.lat) begin
            errors++;
            $display("[TB] FAIL abort_next: got addr=%b err=%b lat=%0d expected addr=111111 err=%b lat=%0d",
                     cur_addr, cur_err, lat, e.err, e.lat);
        end
        complete_handshake();
    endtask

    task automatic test_sweep();
        int   ids[$];
        int   lat;
        int   j;
        int   tmp;
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            sel = c;
            ids.delete();
            for (int i = 0; i < (1 << cfg_ew(c)); i++) ids.push_back(i);
            for (int i = ids.size() - 1; i > 0; i--) begin
                j       = int'($urandom_range(i, 0));
                tmp     = ids[i];
                ids[i]  = ids[j];
                ids[j]  = tmp;
            end
            foreach (ids[n]) begin
                drive_request(ids[n], lat);
                e = sb.pop_front();
                checks++;
                if ({cur_err, cur_addr} !== {e.err, e.addr}) begin
                    errors++;
                    $display("[TB] FAIL sweep_result K=%0d L=%0d id=%0d: got err=%b addr=%b expected err=%b addr=%b",
                             cfg_k[c], cfg_l[c], e.id, cur_err, cur_addr, e.err, e.addr);
                end
                checks++;
                if (lat !== e.lat) begin
                    errors++;
                    $display("[TB] FAIL sweep_latency K=%0d L=%0d id=%0d: got %0d expected %0d",
                             cfg_k[c], cfg_l[c], e.id, lat, e.lat);
                end
                repeat ($urandom_range(2, 0)) @(negedge clk);
                complete_handshake();
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        tb_in_valid  = 1'b0;
        tb_out_ready = 1'b0;
        tb_dest      = '0;
        sel          = 0;
        test_reset();
        test_basic();
        test_k3_range();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_div();
        test_sweep();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fattree_dest_addr_encoder.md
FATTREE_DEST_ADDR_ENCODER -- requirements
Module: fattree_dest_addr_encoder

Interface
REQ-001 The block SHALL have parameter K, default 4: down-ports per router, the radix of each address digit.
REQ-002 The block SHALL have parameter L, default 3: number of fat-tree levels; level 0 is the root, level L-1 is the leaves.
REQ-003 The block SHALL derive Kw=log2(K), LKw=L*Kw, NE=K**L and Ew=log2(NE) as localparams.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: dest_id is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts dest_id.
REQ-008 The block SHALL have port dest_id, input, Ew bits: binary destination endpoint number.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the encoded result is held stable.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port dest_addr_encoded, output, LKw bits: slice [(i+1)*Kw-1:i*Kw] is the down-port digit at level i.
REQ-012 The block SHALL have port out_err, output, 1 bit: dest_id was greater than or equal to NE.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, DIV, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE with in_valid=1: transfer occurs; dest_id is captured as the dividend.
REQ-016 IDLE transfer with dest_id<NE: go to DIV with level counter=L-1, bit counter=Ew-1 and remainder=0.
REQ-017 IDLE transfer with dest_id>=NE: go to DONE with out_err=1 and dest_addr_encoded=0, taking one edge.
REQ-018 DIV SHALL perform restoring division by K, one quotient bit per edge, MSB first, with a remainder register of Kw+1 bits.
REQ-019 After Ew edges of a level, the remainder (Kw bits) SHALL be written to that level's slice, the dividend SHALL be replaced by the quotient, and the level counter SHALL decrement.
REQ-020 Digit order SHALL be: level L-1 receives dest_id mod K, and level 0 receives the most significant base-K digit.
REQ-021 The last DIV edge, at level 0 and bit 0, SHALL go to DONE.
REQ-022 out_valid SHALL assert exactly L*Ew edges after the accepting edge for in-range dest_id.
REQ-023 DONE: dest_addr_encoded and out_err SHALL be held stable until out_ready=1.
REQ-024 The edge with out_valid and out_ready both 1 SHALL go to IDLE; the next request SHALL not be accepted in that same cycle (no bypass).
REQ-025 in_valid SHALL be ignored outside IDLE; the block SHALL not queue a second request.
REQ-026 dest_addr_encoded SHALL be cleared to 0 on each accept, so stale digits are never visible.
REQ-027 The block SHALL use a single datapath for every K; there SHALL be no power-of-two shortcut, so latency is identical for all K.

Reset
REQ-028 reset=1 SHALL asynchronously force state to IDLE.
REQ-029 reset=1 SHALL asynchronously force dest_addr_encoded=0, out_err=0, out_valid=0 and clear all counters and registers.
REQ-030 in_ready SHALL read 1 during and after reset.
REQ-031 Reset asserted mid-DIV or in DONE SHALL abort the transfer silently, with no out_valid pulse.

Structure
REQ-032 The log2 function and the Kw/LKw/NE/Ew derivations SHALL live in the shared fat-tree package used by the router-side routing logic, so that widths match by construction.
REQ-033 The block SHALL use one combinational sub-module, fattree_div_by_k_step, which takes the remainder, the dividend bit and K and returns the next remainder and the quotient bit.
REQ-034 The FSM, counters and output registers SHALL be in the top module.

Verification
REQ-035 Test K=4, L=3, dest_id=27: out_valid at edge 18, dest_addr_encoded=6'b111001, out_err=0.
REQ-036 Test K=3, L=2, dest_id=7: dest_addr_encoded=4'b0110 after 8 edges; with dest_id=12, out_err=1, encoded=0, and out_valid after 1 edge.
REQ-037 Test K=4, L=3 with out_ready held 0 for 10 cycles in DONE: outputs are stable, in_ready=0, and a new in_valid is ignored; release gives in_ready=1 on the next cycle.
REQ-038 Test reset pulsed at DIV edge 7: all outputs are 0 and in_ready=1 immediately; the next request, dest_id=63, returns 6'b111111.
REQ-039 Test a random sweep over all dest_id 0..2**Ew-1 for (K,L) in {(4,3),(3,2),(5,2)}: each digit equals (dest_id/K**(L-1-i)) mod K, and out_err is set iff dest_id>=NE.
